// File: rtl/pc_fetch_issuer_pkg.sv
// Shared types for the PC fetch issuer: the fetch FSM state encoding.
package pc_fetch_issuer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/pc_fetch_issuer_comparator.sv
// Full-width equality comparator used for the PC-unchanged check.
module pc_fetch_issuer_comparator #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             eq
);

   assign eq = (a == b);

endmodule

// File: rtl/pc_fetch_issuer.sv
// Sequential fetch issuer: issues one instruction-memory read whenever pc_in
// moves away from the last serviced PC, and holds the returned instruction.
module pc_fetch_issuer
   import pc_fetch_issuer_pkg::*;
#(
   parameter int unsigned       WIDTH    = 32,
   parameter int unsigned       ILEN     = 32,
   parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pc_in,
   input  logic             flush,
   output logic             mem_req,
   output logic [WIDTH-1:0] mem_addr,
   input  logic             mem_ack,
   input  logic [ILEN-1:0]  mem_rdata,
   output logic [ILEN-1:0]  instr_out,
   output logic             instr_valid,
   output logic             match,
   output logic             stall,
   output logic [1:0]       dbg_state
);

   // Handshake: mem_req is held high from the first REQ/DRAIN cycle until the
   // cycle after mem_ack; mem_addr is stable for that whole window and a
   // transfer completes on any rising edge where mem_req & mem_ack are both 1.

   fetch_state_e     state_q, state_n;
   logic [WIDTH-1:0] last_pc_q, last_pc_n;
   logic             last_vld_q, last_vld_n;
   logic [WIDTH-1:0] req_pc_q, req_pc_n;
   logic [ILEN-1:0]  instr_q, instr_n;
   logic             instr_valid_q, instr_valid_n;
   logic             pc_eq_last;
   logic             pc_eq_req;

   pc_fetch_issuer_comparator #(
      .WIDTH (WIDTH)
   ) u_cmp (
      .a  (pc_in),
      .b  (last_pc_q),
      .eq (pc_eq_last)
   );

   assign pc_eq_req = (pc_in == req_pc_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         last_pc_q     <= RESET_PC;
         last_vld_q    <= 1'b0;
         req_pc_q      <= RESET_PC;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_n;
         last_pc_q     <= last_pc_n;
         last_vld_q    <= last_vld_n;
         req_pc_q      <= req_pc_n;
         instr_q       <= instr_n;
         instr_valid_q <= instr_valid_n;
      end
   end

   always_comb begin
      state_n       = state_q;
      last_pc_n     = last_pc_q;
      last_vld_n    = last_vld_q;
      req_pc_n      = req_pc_q;
      instr_n       = instr_q;
      instr_valid_n = instr_valid_q;

      unique case (state_q)
         ST_IDLE: begin
            if (flush) begin
               last_vld_n    = 1'b0;
               instr_valid_n = 1'b0;
            end else if (!last_vld_q || !pc_eq_last) begin
               req_pc_n      = pc_in;
               instr_valid_n = 1'b0;
               state_n       = ST_REQ;
            end
         end
         ST_REQ: begin
            if (flush) begin
               // An ack arriving with the flush retires the handshake; no drain needed.
               last_vld_n    = 1'b0;
               instr_valid_n = 1'b0;
               state_n       = mem_ack ? ST_IDLE : ST_DRAIN;
            end else if (mem_ack) begin
               state_n = ST_IDLE;
               if (pc_eq_req) begin
                  instr_n       = mem_rdata;
                  last_pc_n     = req_pc_q;
                  last_vld_n    = 1'b1;
                  instr_valid_n = 1'b1;
               end else begin
                  last_vld_n = 1'b0;
               end
            end
         end
         ST_DRAIN: begin
            if (mem_ack) begin
               state_n = ST_IDLE;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   assign mem_req     = (state_q == ST_REQ) || (state_q == ST_DRAIN);
   assign mem_addr    = req_pc_q;
   assign instr_out   = instr_q;
   assign instr_valid = instr_valid_q;
   assign match       = instr_valid_q & pc_eq_last;
   assign stall       = ~match;
   assign dbg_state   = state_q;

endmodule

// File: doc/pc_fetch_issuer.md
# pc_fetch_issuer

Sequential fetch issuer for the decompressor system. It tracks the last serviced PC and, whenever the incoming PC differs from it, issues exactly one instruction-memory read over a req/ack handshake. It then presents the returned instruction to the decode path. It is the producing side of the PC-equality contract: "PC unchanged" means no new instruction, and "PC changed" means fetch and deliver a new one.

## Interface
- WIDTH, 32, PC / address width
- ILEN, 32, instruction word width
- RESET_PC, 0, reset value of the internal last-PC register
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pc_in  in  WIDTH  current PC from the core
- flush  in  1  invalidate held instruction and any in-flight fetch
- mem_req  out  1  read request, level-held until mem_ack
- mem_addr  out  WIDTH  read address, stable while mem_req=1
- mem_ack  in  1  read data valid this cycle; ignored when mem_req=0
- mem_rdata  in  ILEN  read data, sampled when mem_req&mem_ack
- instr_out  out  ILEN  held instruction
- instr_valid  out  1  instr_out belongs to last_pc (registered)
- match  out  1  instr_valid & (pc_in == last_pc), combinational
- stall  out  1  ~match

## Operation
- Registers: state, last_pc, last_vld, req_pc, instr_out, instr_valid.
- States: IDLE, REQ, DRAIN.
- IDLE:
  - If !last_vld or pc_in != last_pc: req_pc<=pc_in, instr_valid<=0, go to REQ.
  - Otherwise hold all registers unchanged; no memory traffic.
- REQ: mem_req=1, mem_addr=req_pc. On mem_ack:
  - If pc_in == req_pc: instr_out<=mem_rdata, last_pc<=req_pc, last_vld<=1, instr_valid<=1, go to IDLE.
  - If pc_in != req_pc: drop data, last_vld<=0, go to IDLE. IDLE refetches on the next cycle.
- DRAIN: mem_req=1, mem_addr=req_pc. On mem_ack: drop data, go to IDLE. Entered only via flush while in REQ.
- Flush, which has priority over every other transition:
  - In IDLE: last_vld<=0, instr_valid<=0, stay in IDLE.
  - In REQ: last_vld<=0, instr_valid<=0, go to DRAIN. If mem_ack arrives in the same cycle, data is dropped and the next state is IDLE.
  - In DRAIN: no change.
- A started handshake is never abandoned. mem_req falls only in the cycle after an ack.
- rst has priority over flush and returns the block to IDLE from any state.
- PC compare is a full WIDTH-bit equality with no masking.

## Timing
- Reset values: state=IDLE, last_pc=RESET_PC, last_vld=0, req_pc=RESET_PC, instr_out=0, instr_valid=0, mem_req=0, mem_addr=RESET_PC, match=0, stall=1.
- The first cycle after reset always fetches, even when pc_in==RESET_PC.
- PC mismatch seen in cycle T: mem_req=1 in T+1.
- With ack in T+1 (zero-wait memory): instr_valid=1 and match=1 in T+2. Minimum latency is 2 cycles.
- Each ack wait state adds 1 cycle.
- match/stall respond combinationally to pc_in in the same cycle.
- mem_req is registered-state driven; it is never asserted in IDLE.
- Reset during REQ/DRAIN drops mem_req in the next cycle. The memory side tolerates this abort.

## Structure
- Shared package holds the fetch-state enum (IDLE, REQ, DRAIN), encoded as 2 bits.
- The equality check instantiates the existing COMPARATOR with WIDTH passed through (a=pc_in, b=last_pc). No other sub-modules.

## Test plan
- Reset with pc_in=0: mem_req=1 one cycle after reset release, mem_addr=0. Ack with rdata=0x00000013 -> next cycle instr_valid=1, instr_out=0x00000013, match=1.
- Hold pc_in=0x100 for 10 cycles after the fetch completes -> exactly one mem_req handshake total; match stays 1.
- pc_in 0x100→0x104 with ack delayed 3 cycles -> mem_addr=0x104 stable for 4 cycles, stall=1 throughout, then instr_valid=1 with the new data.
- pc_in changes to 0x108 while a 0x104 request is outstanding -> 0x104 data dropped (instr_valid stays 0), followed by a fresh request with mem_addr=0x108.
- flush during REQ at 0x200 -> mem_req held until ack, data dropped, then refetch of 0x200 with a second handshake.
- flush and mem_ack in the same cycle in REQ -> no instr_valid, state IDLE, refetch begins the next cycle. rst asserted mid-REQ -> mem_req=0 next cycle and all reset values restored.
